// File: rtl/alu_mul_sequencer.sv
// Shift-add multiplier that borrows the shared ALU (add op) for WIDTH steps
// and returns the low WIDTH bits of opA*opB. Optional: MUL_EARLY_EXIT_EN.
module alu_mul_sequencer #(
  parameter int         WIDTH  = 16,
  parameter logic [2:0] ADD_OP = 3'b000,
  parameter int         CNT_W  = 5
) (
  input  logic             CLK,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic             aluReq,
  output logic [WIDTH-1:0] aluA,
  output logic [WIDTH-1:0] aluB,
  output logic [2:0]       aluOp,
  input  logic [WIDTH-1:0] aluResult
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] mcand_reg, mcand_next;
  logic [WIDTH-1:0] mplier_reg, mplier_next;
  logic [WIDTH-1:0] product_reg, product_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             early_exit;

`ifdef MUL_EARLY_EXIT_EN
  // No multiplier bits left: remaining steps would only shift, so stop now.
  assign early_exit = (mplier_reg == '0);
`else
  assign early_exit = 1'b0;
`endif

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      mcand_reg   <= '0;
      mplier_reg  <= '0;
      product_reg <= '0;
      count_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      mcand_reg   <= mcand_next;
      mplier_reg  <= mplier_next;
      product_reg <= product_next;
      count_reg   <= count_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    mcand_next   = mcand_reg;
    mplier_next  = mplier_reg;
    product_next = product_reg;
    count_next   = count_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          mcand_next   = opA;
          mplier_next  = opB;
          product_next = '0;
          count_next   = '0;
          state_next   = RUN;
        end
      end
      RUN: begin
        if (early_exit) begin
          state_next = DONE;
        end else begin
          if (mplier_reg[0]) product_next = aluResult;
          mcand_next  = mcand_reg << 1;
          mplier_next = mplier_reg >> 1;
          count_next  = count_reg + 1'b1;
          if (count_reg == LAST_STEP) state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy    = (state_reg != IDLE);
  assign done    = (state_reg == DONE);
  assign aluReq  = (state_reg == RUN);
  assign product = product_reg;

  // ALU inputs are held at zero outside RUN so the shared ALU stays quiet.
  assign aluA  = aluReq ? product_reg : '0;
  assign aluB  = aluReq ? mcand_reg   : '0;
  assign aluOp = aluReq ? ADD_OP      : 3'b000;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Self-checking bench for alu_mul_sequencer: vector table, corner-case
// sequences and randomized back-to-back operations against a reference model.
module tb_alu_mul_sequencer;

  localparam int         WIDTH  = 16;
  localparam logic [2:0] ADD_OP = 3'b000;

  logic             CLK = 1'b0;
  logic             reset_n;
  logic             start;
  logic [WIDTH-1:0] opA, opB;
  logic             busy, done, aluReq;
  logic [WIDTH-1:0] product, aluA, aluB, aluResult;
  logic [2:0]       aluOp;

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  // Shared ALU stand-in: combinational add.
  assign aluResult = aluA + aluB;

  alu_mul_sequencer #(.WIDTH(WIDTH), .ADD_OP(ADD_OP), .CNT_W(5)) dut (
    .CLK(CLK), .reset_n(reset_n), .start(start), .opA(opA), .opB(opB),
    .busy(busy), .done(done), .product(product), .aluReq(aluReq),
    .aluA(aluA), .aluB(aluB), .aluOp(aluOp), .aluResult(aluResult)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] p;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [15:0] model_product(input logic [15:0] a, input logic [15:0] b);
    logic [31:0] full;
    full = 32'(a) * 32'(b);
    return full[15:0];
  endfunction

  // Number of clocks spent in RUN for multiplier b.
  function automatic int model_runs(input logic [15:0] b);
`ifdef MUL_EARLY_EXIT_EN
    int hb;
    hb = -1;
    for (int k = 0; k < 16; k++) if (b[k]) hb = k;
    if (hb < 0) return 1;
    return (hb + 2 > 16) ? 16 : hb + 2;
`else
    return 16;
`endif
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge with it idle again.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic [15:0] exp_p,
                       input bit hold, input bit inject, input string tag);
    int          done_at, done_n, busy_n, req_n, alu_bad, runs;
    bit          finished;
    logic [15:0] prod_seen;
    done_at = -1; done_n = 0; busy_n = 0; req_n = 0; alu_bad = 0;
    finished = 1'b0; prod_seen = '0;
    runs = model_runs(b);
    opA = a; opB = b; start = 1'b1;
    @(posedge CLK); #1;
    if (!hold) start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (busy) busy_n++;
      if (aluReq) begin
        req_n++;
        if (aluOp !== ADD_OP) alu_bad++;
      end else if (aluA !== '0 || aluB !== '0 || aluOp !== 3'b000) begin
        alu_bad++;
      end
      if (done) begin
        done_n++;
        done_at = i;
        prod_seen = product;
      end
      if (inject && i == 4) begin opA = 16'd9; opB = 16'd9; start = 1'b1; end
      if (inject && i == 5) start = 1'b0;
      if (!busy) begin finished = 1'b1; break; end
    end
    chk({tag, " finished"}, 32'(finished), 32'd1);
    chk({tag, " product"}, 32'(prod_seen), 32'(exp_p));
    chk({tag, " product held"}, 32'(product), 32'(exp_p));
    chk({tag, " done pulses"}, done_n, 1);
    chk({tag, " done latency"}, done_at, runs);
    chk({tag, " busy clocks"}, busy_n, runs + 1);
    chk({tag, " aluReq clocks"}, req_n, runs);
    chk({tag, " alu idle/op"}, alu_bad, 0);
    $display("[TB] %s a=%h b=%h product=%h done_at=%0d busy=%0d", tag, a, b, prod_seen, done_at, busy_n);
  endtask

  vec_t tbl[6];

  initial begin
    int          dn;
    logic [15:0] ra, rb;

    tbl[0] = '{16'd3,    16'd5,    16'd15};
    tbl[1] = '{16'hFFFE, 16'd7,    16'hFFF2};
    tbl[2] = '{16'h0100, 16'h0100, 16'h0000};
    tbl[3] = '{16'h1234, 16'h0000, 16'h0000};
    tbl[4] = '{16'hFFFF, 16'hFFFF, 16'h0001};
    tbl[5] = '{16'h8001, 16'h8000, 16'h8000};

    reset_n = 1'b0; start = 1'b0; opA = '0; opB = '0;
    #12;
    chk("reset busy", 32'(busy), 0);
    chk("reset done", 32'(done), 0);
    chk("reset product", 32'(product), 0);
    chk("reset aluReq", 32'(aluReq), 0);
    chk("reset aluA/B/Op", {aluOp, aluA ^ aluB}, 0);
    @(negedge CLK);
    reset_n = 1'b1;
    @(negedge CLK);

    for (int i = 0; i < 6; i++) do_op(tbl[i].a, tbl[i].b, tbl[i].p, 1'b0, 1'b0, "vec");

    // start pulsed mid-RUN with new operands must not disturb 6*7
    do_op(16'd6, 16'd7, 16'd42, 1'b0, 1'b1, "start-while-busy");
    dn = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (done || busy) dn++;
    end
    chk("no stray operation", dn, 0);

    // Asynchronous reset in RUN cycle 8
    opA = 16'd3; opB = 16'd5; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    repeat (8) @(negedge CLK);
    chk("mid-run product nonzero", 32'(product != '0), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("async rst busy", 32'(busy), 0);
    chk("async rst done", 32'(done), 0);
    chk("async rst aluReq", 32'(aluReq), 0);
    chk("async rst product", 32'(product), 0);
    chk("async rst aluA", 32'(aluA), 0);
    chk("async rst aluB", 32'(aluB), 0);
    @(negedge CLK);
    chk("rst held done", 32'(done), 0);
    reset_n = 1'b1;
    do_op(16'd10, 16'd10, 16'd100, 1'b0, 1'b0, "after-reset");

    // Back-to-back random operations with start held high
    for (int i = 0; i < 20; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom) >> $urandom_range(0, 15);
      do_op(ra, rb, model_product(ra, rb), 1'b1, 1'b0, "rand");
    end
    start = 1'b0;
    repeat (3) @(negedge CLK);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
